// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, digit
// encoding, recoding helper and width helpers.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit: bit 2 = negate, bits 1:0 = magnitude (0, 1 or 2).
    typedef logic [2:0] digit_t;

    localparam digit_t ZERO = 3'b000;
    localparam digit_t POS1 = 3'b001;
    localparam digit_t POS2 = 3'b010;
    localparam digit_t NEG1 = 3'b101;
    localparam digit_t NEG2 = 3'b110;

    // Number of radix-4 digits over the (n+2)-bit extended multiplier.
    function automatic int unsigned iter_count(input int unsigned n);
        return n / 2 + 1;
    endfunction

    // Iteration counter width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n / 2 + 2);
    endfunction

    // Recode {b[i+1], b[i], b[i-1]} into a radix-4 Booth digit.
    function automatic digit_t booth_digit(input logic [2:0] bits);
        digit_t d;
        d = ZERO;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// Combinational radix-4 Booth partial-product selector.
//   bits   : {b[i+1], b[i], b[i-1]} recoding window
//   mcand  : multiplicand already extended to N+2 bits
//   pp     : signed multiple {-2,-1,0,+1,+2} * mcand, N+3 bits
module booth_r4_digit_sel
    import booth_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [2:0]   bits,
    input  logic [N+1:0] mcand,
    output logic [N+2:0] pp
);

    localparam int unsigned PW = N + 3;

    digit_t          digit;
    logic            neg;
    logic [PW-1:0]   mag;

    // Pick |multiple|, then negate by inverting and adding the carry-in.
    always_comb begin
        digit = booth_digit(bits);
        neg   = digit[2];
        mag   = '0;
        case (digit)
            POS1, NEG1: mag = {mcand[N+1], mcand};
            POS2, NEG2: mag = {mcand, 1'b0};
            default:    mag = '0;
        endcase
        pp = (neg ? ~mag : mag) + PW'(neg);
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Iterative radix-4 Booth multiplier, two multiplier bits retired per cycle.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : accepted in IDLE or DONE
//   is_signed     : 1 = two's complement operands, 0 = unsigned
//   multiplicand  : operand A, latched on accept
//   multiplier    : operand B, latched on accept
//   product       : registered 2N-bit result, updated only on completion
//   busy          : high while in CALC
//   done          : one-cycle completion pulse
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int unsigned XW   = N + 2;
    localparam int unsigned AW   = 2 * N + 4;
    localparam int unsigned ITER = iter_count(N);
    localparam int unsigned CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t         state, state_next;
    logic [XW-1:0]  mcand_q;
    logic [XW-1:0]  mq_q;
    logic           q_m1;
    logic [AW-1:0]  acc_q;
    logic [CW-1:0]  cnt_q;

    logic           accept_c;
    logic           last_c;
    logic [XW:0]    pp_c;
    logic [XW+1:0]  hi_sum_c;
    logic [AW+1:0]  sum_full_c;
    logic [AW-1:0]  acc_next_c;

    booth_r4_digit_sel #(.N(N)) u_digit_sel (
        .bits  ({mq_q[1], mq_q[0], q_m1}),
        .mcand (mcand_q),
        .pp    (pp_c)
    );

    // Add the multiple into the upper half, then arithmetic shift right by 2.
    // The sum is held two bits wider so the pre-shift value cannot overflow.
    always_comb begin
        accept_c   = start && ((state == IDLE) || (state == DONE));
        last_c     = (state == CALC) && (cnt_q == LAST);
        hi_sum_c   = {{2{acc_q[AW-1]}}, acc_q[AW-1:XW]} + {pp_c[XW], pp_c};
        sum_full_c = {hi_sum_c, acc_q[XW-1:0]};
        acc_next_c = AW'($signed(sum_full_c) >>> 2);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_q == LAST) state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q <= '0;
            mq_q    <= '0;
            q_m1    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_next == CALC);
            done <= (state_next == DONE);
            if (accept_c) begin
                mcand_q <= {{2{is_signed & multiplicand[N-1]}}, multiplicand};
                mq_q    <= {{2{is_signed & multiplier[N-1]}}, multiplier};
                q_m1    <= 1'b0;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state == CALC) begin
                acc_q <= acc_next_c;
                mq_q  <= {{2{mq_q[XW-1]}}, mq_q[XW-1:2]};
                q_m1  <= mq_q[1];
                cnt_q <= cnt_q + CW'(1);
                if (last_c) begin
                    product <= acc_next_c[2*N-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier at N=8 and N=64.
module tb_booth_radix4_multiplier;

    localparam int ITER8  = 5;
    localparam int ITER64 = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         st8, sg8, busy8, done8;
    logic [7:0]   a8, b8;
    logic [15:0]  p8;
    logic         st64, sg64, busy64, done64;
    logic [63:0]  a64, b64;
    logic [127:0] p64;

    int total = 0;
    int bad   = 0;
    logic [127:0] last8, last64;

    booth_radix4_multiplier #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .is_signed(sg8),
        .multiplicand(a8), .multiplier(b8),
        .product(p8), .busy(busy8), .done(done8)
    );

    booth_radix4_multiplier #(.N(64)) u64 (
        .clk(clk), .rst(rst), .start(st64), .is_signed(sg64),
        .multiplicand(a64), .multiplier(b64),
        .product(p64), .busy(busy64), .done(done64)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: extend both operands to 128 bits and multiply.
    function automatic logic [127:0] ref_mul(input bit w64, input logic [63:0] a,
                                             input logic [63:0] b, input logic sgn);
        logic [127:0] ax, bx, p;
        ax = w64 ? {{64{sgn & a[63]}}, a} : {{120{sgn & a[7]}}, a[7:0]};
        bx = w64 ? {{64{sgn & b[63]}}, b} : {{120{sgn & b[7]}}, b[7:0]};
        p  = ax * bx;
        if (!w64) p[127:16] = '0;
        return p;
    endfunction

    task automatic issue(input bit w64, input logic [63:0] a, input logic [63:0] b, input logic sgn);
        if (w64) begin a64 = a; b64 = b; sg64 = sgn; st64 = 1'b1; end
        else     begin a8 = a[7:0]; b8 = b[7:0]; sg8 = sgn; st8 = 1'b1; end
    endtask

    // Called at a negedge with start driven; follows the op to its done pulse.
    task automatic complete(input bit w64, input string tag, input logic [127:0] exp,
                            input bit jam, input bit chain);
        int iter, j, lat, nbusy;
        bit seen, both, moved;
        logic bsy, dn;
        logic [127:0] prod, held;
        iter = w64 ? ITER64 : ITER8;
        held = w64 ? last64 : last8;
        j = 0; lat = -1; nbusy = 0; seen = 0; both = 0; moved = 0;
        @(posedge clk);
        while (!seen && j < iter + 4) begin
            @(negedge clk);
            j++;
            bsy  = w64 ? busy64 : busy8;
            dn   = w64 ? done64 : done8;
            prod = w64 ? p64 : {112'b0, p8};
            if (j == 1) begin
                chk({tag, ":busy_first"}, {127'b0, bsy}, 128'd1);
                chk({tag, ":done_first"}, {127'b0, dn}, 128'd0);
                chk({tag, ":held_first"}, prod, held);
            end
            if (bsy && dn) both = 1;
            if (bsy) nbusy++;
            if (dn) begin
                seen = 1;
                lat  = j - 1;
            end else if (prod !== held) begin
                moved = 1;
            end
            if (seen || !jam) begin
                if (w64) st64 = 1'b0; else st8 = 1'b0;
            end else if (w64) begin
                st64 = 1'($urandom % 2); sg64 = 1'($urandom % 2);
                a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            end else begin
                st8 = 1'($urandom % 2); sg8 = 1'($urandom % 2);
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        chk({tag, ":latency"}, 128'(lat), 128'(iter));
        chk({tag, ":busy_cycles"}, 128'(nbusy), 128'(iter));
        chk({tag, ":busy_and_done"}, {127'b0, both}, 128'd0);
        chk({tag, ":product_moved"}, {127'b0, moved}, 128'd0);
        chk({tag, ":product"}, prod, exp);
        if (w64) last64 = exp; else last8 = exp;
        if (!chain) begin
            @(negedge clk);
            chk({tag, ":done_pulse"}, {127'b0, (w64 ? done64 : done8)}, 128'd0);
            chk({tag, ":busy_after"}, {127'b0, (w64 ? busy64 : busy8)}, 128'd0);
        end
    endtask

    initial begin
        logic [63:0] ra, rb, ra2, rb2;
        logic        rs, rs2;
        rst = 1'b0;
        st8 = 0; sg8 = 0; a8 = '0; b8 = '0;
        st64 = 0; sg64 = 0; a64 = '0; b64 = '0;
        last8 = '0; last64 = '0;
        #1;
        chk("reset:p8", {112'b0, p8}, 128'd0);
        chk("reset:busy8", {127'b0, busy8}, 128'd0);
        chk("reset:done8", {127'b0, done8}, 128'd0);
        chk("reset:p64", p64, 128'd0);
        chk("reset:busy64", {127'b0, busy64}, 128'd0);
        chk("reset:done64", {127'b0, done64}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // N=8 extremes
        issue(0, 64'h80, 64'h80, 1'b1);
        complete(0, "s8_min_min", 128'h4000, 0, 0);
        issue(0, 64'hFF, 64'hFF, 1'b0);
        complete(0, "u8_max_max", 128'hFE01, 0, 0);
        issue(0, 64'hFF, 64'hFF, 1'b1);
        complete(0, "s8_m1_m1", 128'h0001, 0, 0);

        // N=64 directed
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        complete(1, "s64_m1_x1", {128{1'b1}}, 0, 0);
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        complete(1, "u64_max_x2", 128'h1_FFFF_FFFF_FFFF_FFFE, 0, 0);

        // Inputs thrashed during CALC must not disturb the op
        issue(1, 64'd3, 64'd5, 1'b0);
        complete(1, "s64_jam", 128'd15, 1, 0);

        // Random N=8
        for (int i = 0; i < 8; i++) begin
            ra = 64'($urandom); rb = 64'($urandom); rs = 1'($urandom % 2);
            issue(0, ra, rb, rs);
            complete(0, "rand8", ref_mul(0, ra, rb, rs), 0, 0);
        end

        // Random N=64
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom % 2);
            issue(1, ra, rb, rs);
            complete(1, "rand64", ref_mul(1, ra, rb, rs), 0, 0);
        end

        // Back-to-back: second start issued in the DONE cycle
        ra = 64'($urandom); rb = 64'($urandom); rs = 1'($urandom % 2);
        ra2 = 64'($urandom); rb2 = 64'($urandom); rs2 = 1'($urandom % 2);
        issue(0, ra, rb, rs);
        complete(0, "b2b8_first", ref_mul(0, ra, rb, rs), 0, 1);
        issue(0, ra2, rb2, rs2);
        complete(0, "b2b8_second", ref_mul(0, ra2, rb2, rs2), 0, 0);
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        ra2 = {$urandom, $urandom}; rb2 = {$urandom, $urandom};
        issue(1, ra, rb, 1'b1);
        complete(1, "b2b64_first", ref_mul(1, ra, rb, 1'b1), 0, 1);
        issue(1, ra2, rb2, 1'b0);
        complete(1, "b2b64_second", ref_mul(1, ra2, rb2, 1'b0), 0, 0);

        // Asynchronous reset in the middle of an operation
        issue(1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        @(posedge clk);
        @(negedge clk);
        st64 = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset:p64", p64, 128'd0);
        chk("midreset:done64", {127'b0, done64}, 128'd0);
        chk("midreset:busy64", {127'b0, busy64}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        last64 = '0;
        last8  = '0;
        @(negedge clk);
        issue(1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        complete(1, "after_reset", ref_mul(1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1), 0, 0);
        chk("after_reset:neg42", p64, {{120{1'b1}}, 8'hD6});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_radix4_multiplier.md
Name: booth_radix4_multiplier

Overview:
Parametrised, iterative radix-4 Booth multiplier. It succeeds the fixed 64-bit radix-2 multiplier.
- Operand width N is generic.
- Signed or unsigned mode is selected per operation.
- Returns the full 2N-bit product.
- Retires two multiplier bits per cycle.
- Sits behind the same start/done control style, so top-level wrappers can drop it in with N=64.

Parameters:
N, 64, operand width in bits; must be even and >= 4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when the FSM is in IDLE or DONE
is_signed  input  1  1 = both operands two's complement; 0 = both unsigned; latched with operands
multiplicand  input  N  operand A; latched on accepted start
multiplier  input  N  operand B; latched on accepted start
product  output  2N  registered result; holds until the next completion
busy  output  1  high while in CALC
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - product=0, done=0, busy=0, iteration counter=0.
  - Any operation in flight is discarded.
  - Release is synchronous to clk.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge k: latch operands and is_signed, clear accumulator, count=0, go to CALC.
- Operand extension at latch:
  - Both operands are extended to N+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - Booth recoding runs over the extended multiplier with an implicit 0 below bit 0.
  - This gives ITER = N/2+1 radix-4 digits (33 for N=64).
  - The same iteration count is used in both modes.
- CALC:
  - busy=1.
  - Per edge, recode 3 bits to a digit in {-2,-1,0,+1,+2}.
  - Add the selected multiple of the extended multiplicand to the upper accumulator.
  - Arithmetic-shift the accumulator right by 2; count increments.
  - Accumulator width: 2N+4 bits.
  - On the edge performing digit ITER-1 (edge k+ITER): product <= low 2N bits of the final accumulator, go to DONE.
  - start is ignored in CALC. Operand and is_signed input changes have no effect.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - Next edge with start=0: go to IDLE.
  - Next edge with start=1: accepted as a new operation, exactly as from IDLE (back-to-back). done still drops after one cycle.
- Latency:
  - done is high in the cycle following edge k+ITER.
  - Throughput is one result per ITER+1 cycles.
- product changes only on the completion edge or on reset. It is stable while busy.
- Exactness: the true product always fits in 2N bits.
  - Signed range: -2^(2N-2)+2^(N-1) .. 2^(2N-2).
  - Unsigned range: up to (2^N-1)^2.
  - No overflow flag.
- busy and done are never high simultaneously.

Decomposition:
- Shared package booth_pkg:
  - FSM state encoding (IDLE/CALC/DONE).
  - Booth digit encoding constants: ZERO, POS1, POS2, NEG1, NEG2.
  - Width helper for ITER and the counter width, clog2(N/2+2).
- One combinational sub-module, booth_r4_digit_sel:
  - Inputs: 3 recoding bits and the extended multiplicand.
  - Output: the (N+3)-bit signed partial-product multiple. Negation is via invert plus carry-in.
  - Reusable by a future pipelined array variant.

Test Plan:
1. N=8, is_signed=1, A=-128, B=-128 -> done pulse visible after edge k+5; product=16'h4000; busy high exactly 5 cycles.
2. N=8, is_signed=0, A=255, B=255 -> product=16'hFE01. Same operands with is_signed=1 (-1*-1) -> product=16'h0001.
3. N=64, is_signed=1, A=-1, B=1 -> product=128'hFFFF...FFFF (all ones). is_signed=0, A=64'hFFFF_FFFF_FFFF_FFFF, B=2 -> product=128'h1_FFFF_FFFF_FFFF_FFFE; done after edge k+33.
4. N=64, start at edge k with A=3, B=5, then pulse start and change A/B/is_signed every cycle during CALC -> no restart; product=15; single done pulse at edge k+33.
5. Reset mid-op: drive rst low during iteration 10 -> product=0, done=0, busy=0 immediately (no clock needed). After release, start A=7, B=-6 (signed) -> product=-42 (sign-extended to 2N bits).
6. Back-to-back: assert start during the DONE cycle with new operands -> busy re-asserts the next cycle. Each operation yields exactly one one-cycle done pulse. The first product holds until the second completion edge.
